// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexes four 7-segment digit buses (HH:MM) onto one shared
// segment bus plus four one-hot digit enables. Each digit owns a slot of
// SCAN_DIV cycles. The first BLANK_CYC cycles of a slot are always dark
// to suppress ghosting. The digit is then lit for lit_len cycles, where
// lit_len scales with the brightness level. All inputs are snapshotted once
// per 4-digit frame so a digit can never tear mid-frame.
//
// Ports:
//   sysclk_i      in   system clock
//   rst_i         in   asynchronous active-high reset
//   en_i          in   scan enable (0: dark, counters parked at frame start)
//   segment_hxxx  in   hours-tens segments   {g..a}
//   segment_xhxx  in   hours-units segments
//   segment_xxmx  in   minutes-tens segments
//   segment_xxxm  in   minutes-units segments
//   dp_mask_i     in   decimal point per digit, bit0 = hours tens
//   brightness_i  in   PWM duty level, 0 dimmest, all-ones full
//   seg_o         out  shared segment bus (registered)
//   dp_o          out  shared decimal point (registered)
//   digit_an_o    out  one-hot digit enable, bit0 = hours tens (registered)
//   frame_o       out  one-cycle pulse after the last cycle of each frame
// ---------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int SCAN_DIV  = 32,
    parameter int BLANK_CYC = 2,
    parameter int PWM_BITS  = 3
) (
    input  logic                sysclk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [6:0]          segment_hxxx,
    input  logic [6:0]          segment_xhxx,
    input  logic [6:0]          segment_xxmx,
    input  logic [6:0]          segment_xxxm,
    input  logic [3:0]          dp_mask_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic [6:0]          seg_o,
    output logic                dp_o,
    output logic [3:0]          digit_an_o,
    output logic                frame_o
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // lit_len must be able to hold SCAN_DIV itself
    localparam int LW = $clog2(SCAN_DIV + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    // Floored on-time for a given brightness level
    function automatic logic [LW-1:0] f_lit_len(input logic [PWM_BITS-1:0] b);
        logic [31:0] prod;
        prod = 32'(SCAN_DIV - BLANK_CYC) * (32'(b) + 32'd1);
        return LW'(prod >> PWM_BITS);
    endfunction

    logic [SW-1:0] r_slot_cnt;
    logic [1:0]    r_digit_idx;
    logic [6:0]    r_snap_h;
    logic [6:0]    r_snap_hu;
    logic [6:0]    r_snap_mt;
    logic [6:0]    r_snap_mu;
    logic [3:0]    r_dp_snap;
    logic [LW-1:0] r_lit_len;

    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;
    logic          r_frame;

    logic          w_frame_start;
    logic          w_slot_last;
    logic          w_frame_end;
    logic [LW-1:0] w_cur_len;
    logic [6:0]    w_cur_seg;
    logic          w_cur_dp;
    logic          w_lit;

    // Frame-start detection, snapshot bypass and lit-window decision
    always_comb begin
        w_frame_start = 1'b0;
        w_slot_last   = 1'b0;
        w_frame_end   = 1'b0;
        w_cur_len     = r_lit_len;
        w_cur_seg     = 7'd0;
        w_cur_dp      = 1'b0;
        w_lit         = 1'b0;

        if (en_i && (r_slot_cnt == {SW{1'b0}}) && (r_digit_idx == 2'd0)) begin
            w_frame_start = 1'b1;
        end else begin
            w_frame_start = 1'b0;
        end

        if (r_slot_cnt == SLOT_LAST) begin
            w_slot_last = 1'b1;
        end else begin
            w_slot_last = 1'b0;
        end

        if (w_slot_last && (r_digit_idx == 2'd3)) begin
            w_frame_end = 1'b1;
        end else begin
            w_frame_end = 1'b0;
        end

        // At frame start the registers are still being loaded, so use the
        // values that are being latched this very cycle.
        if (w_frame_start) begin
            w_cur_len = f_lit_len(brightness_i);
        end else begin
            w_cur_len = r_lit_len;
        end

        case (r_digit_idx)
            2'd0: begin
                if (w_frame_start) begin
                    w_cur_seg = segment_hxxx;
                    w_cur_dp  = dp_mask_i[0];
                end else begin
                    w_cur_seg = r_snap_h;
                    w_cur_dp  = r_dp_snap[0];
                end
            end
            2'd1: begin
                w_cur_seg = r_snap_hu;
                w_cur_dp  = r_dp_snap[1];
            end
            2'd2: begin
                w_cur_seg = r_snap_mt;
                w_cur_dp  = r_dp_snap[2];
            end
            2'd3: begin
                w_cur_seg = r_snap_mu;
                w_cur_dp  = r_dp_snap[3];
            end
            default: begin
                w_cur_seg = 7'd0;
                w_cur_dp  = 1'b0;
            end
        endcase

        if ((32'(r_slot_cnt) >= 32'(BLANK_CYC)) &&
            (32'(r_slot_cnt) < (32'(BLANK_CYC) + 32'(w_cur_len)))) begin
            w_lit = 1'b1;
        end else begin
            w_lit = 1'b0;
        end
    end

    // Slot and digit counters; parked at frame start while disabled
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot_cnt  <= {SW{1'b0}};
            r_digit_idx <= 2'd0;
        end else if (!en_i) begin
            r_slot_cnt  <= {SW{1'b0}};
            r_digit_idx <= 2'd0;
        end else if (w_slot_last) begin
            r_slot_cnt  <= {SW{1'b0}};
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_slot_cnt  <= r_slot_cnt + {{(SW-1){1'b0}}, 1'b1};
            r_digit_idx <= r_digit_idx;
        end
    end

    // Frame-coherent snapshot of all digit data and the on-time
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            r_snap_h  <= 7'd0;
            r_snap_hu <= 7'd0;
            r_snap_mt <= 7'd0;
            r_snap_mu <= 7'd0;
            r_dp_snap <= 4'd0;
            r_lit_len <= {LW{1'b0}};
        end else if (w_frame_start) begin
            r_snap_h  <= segment_hxxx;
            r_snap_hu <= segment_xhxx;
            r_snap_mt <= segment_xxmx;
            r_snap_mu <= segment_xxxm;
            r_dp_snap <= dp_mask_i;
            r_lit_len <= w_cur_len;
        end else begin
            r_snap_h  <= r_snap_h;
            r_snap_hu <= r_snap_hu;
            r_snap_mt <= r_snap_mt;
            r_snap_mu <= r_snap_mu;
            r_dp_snap <= r_dp_snap;
            r_lit_len <= r_lit_len;
        end
    end

    // Output registers: one cycle from counter state to pins
    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            r_seg   <= 7'd0;
            r_dp    <= 1'b0;
            r_an    <= 4'd0;
            r_frame <= 1'b0;
        end else if (!en_i) begin
            r_seg   <= 7'd0;
            r_dp    <= 1'b0;
            r_an    <= 4'd0;
            r_frame <= 1'b0;
        end else if (w_lit) begin
            r_seg   <= w_cur_seg;
            r_dp    <= w_cur_dp;
            r_an    <= 4'b0001 << r_digit_idx;
            r_frame <= w_frame_end;
        end else begin
            r_seg   <= 7'd0;
            r_dp    <= 1'b0;
            r_an    <= 4'd0;
            r_frame <= w_frame_end;
        end
    end

    assign seg_o      = r_seg;
    assign dp_o       = r_dp;
    assign digit_an_o = r_an;
    assign frame_o    = r_frame;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [6:0] seg_h  = 7'd0;
    logic [6:0] seg_hu = 7'd0;
    logic [6:0] seg_mt = 7'd0;
    logic [6:0] seg_mu = 7'd0;
    logic [3:0] dp_mask = 4'd0;
    logic [2:0] bright  = 3'd0;

    logic [6:0] seg_o;
    logic       dp_o;
    logic [3:0] an_o;
    logic       frame_o;

    logic [6:0] v_seg;
    logic       v_dp;
    logic [3:0] v_an;
    logic       v_frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_mux dut (
        .sysclk_i(clk), .rst_i(rst), .en_i(en),
        .segment_hxxx(seg_h), .segment_xhxx(seg_hu),
        .segment_xxmx(seg_mt), .segment_xxxm(seg_mu),
        .dp_mask_i(dp_mask), .brightness_i(bright),
        .seg_o(seg_o), .dp_o(dp_o), .digit_an_o(an_o), .frame_o(frame_o)
    );

    seg_scan_mux #(.SCAN_DIV(8), .BLANK_CYC(1), .PWM_BITS(3)) dut_v (
        .sysclk_i(clk), .rst_i(rst), .en_i(en),
        .segment_hxxx(seg_h), .segment_xhxx(seg_hu),
        .segment_xxmx(seg_mt), .segment_xxxm(seg_mu),
        .dp_mask_i(dp_mask), .brightness_i(bright),
        .seg_o(v_seg), .dp_o(v_dp), .digit_an_o(v_an), .frame_o(v_frame)
    );

    // ---------------- scoreboard for the default-parameter instance --------
    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       frame;
    } out_t;

    out_t sb_q[$];

    int         m_slot = 0;
    int         m_dig  = 0;
    logic [6:0] m_snap [4] = '{7'd0, 7'd0, 7'd0, 7'd0};
    logic [3:0] m_dp   = 4'd0;
    int         m_len  = 0;

    // Reference model: expected outputs for each edge are queued here
    always @(posedge clk or posedge rst) begin : model
        out_t       e;
        logic [6:0] cur_in [4];
        int         len;
        logic       fs;
        if (rst) begin
            m_slot <= 0;
            m_dig  <= 0;
            m_dp   <= 4'd0;
            m_len  <= 0;
            for (int i = 0; i < 4; i++) m_snap[i] <= 7'd0;
            sb_q.delete();
        end else begin
            e = '0;
            if (en) begin
                fs = (m_slot == 0) && (m_dig == 0);
                cur_in = '{seg_h, seg_hu, seg_mt, seg_mu};
                len = fs ? ((30 * (int'(bright) + 1)) >> 3) : m_len;
                if ((m_slot >= 2) && (m_slot < 2 + len)) begin
                    e.an  = 4'b0001 << m_dig;
                    e.seg = fs ? cur_in[m_dig] : m_snap[m_dig];
                    e.dp  = fs ? dp_mask[m_dig] : m_dp[m_dig];
                end
                e.frame = (m_dig == 3) && (m_slot == 31);
                if (fs) begin
                    for (int i = 0; i < 4; i++) m_snap[i] <= cur_in[i];
                    m_dp  <= dp_mask;
                    m_len <= len;
                end
                if (m_slot == 31) begin
                    m_slot <= 0;
                    m_dig  <= (m_dig + 1) % 4;
                end else begin
                    m_slot <= m_slot + 1;
                end
            end else begin
                m_slot <= 0;
                m_dig  <= 0;
            end
            sb_q.push_back(e);
        end
    end

    // Compare DUT outputs against the queue away from the active edge
    always @(negedge clk) begin : monitor
        out_t e;
        if (rst) begin
            checks++;
            if ({seg_o, dp_o, an_o, frame_o} !== 13'd0) begin
                errors++;
                $display("FAIL sb_reset t=%0t got seg=%h dp=%b an=%b fr=%b want all 0",
                         $time, seg_o, dp_o, an_o, frame_o);
            end
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({seg_o, dp_o, an_o, frame_o} !== e) begin
                errors++;
                $display("FAIL sb_cycle t=%0t got seg=%h dp=%b an=%b fr=%b want seg=%h dp=%b an=%b fr=%b",
                         $time, seg_o, dp_o, an_o, frame_o, e.seg, e.dp, e.an, e.frame);
            end
        end
    end

    // Wait (bounded) for a frame pulse on the chosen instance
    task automatic sync_frame(input bit use_v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((use_v ? v_frame : frame_o) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [6:0] tbl [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fr;
        int s, d;
        rst = 1'b1; en = 1'b1; bright = 3'd7; dp_mask = 4'd0;
        seg_h = 7'h06; seg_hu = 7'h5B; seg_mt = 7'h4F; seg_mu = 7'h66;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({seg_o, dp_o, an_o, frame_o} !== 13'd0) begin
            errors++;
            $display("FAIL reset_async got seg=%h an=%b fr=%b want 0", seg_o, an_o, frame_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int n = 1; n <= 256; n++) begin
            @(negedge clk);
            s = (n - 1) % 32;
            d = ((n - 1) / 32) % 4;
            exp_an  = (s >= 2) ? (4'b0001 << d) : 4'd0;
            exp_seg = (s >= 2) ? tbl[d] : 7'd0;
            exp_fr  = ((n % 128) == 0);
            checks++;
            if ({an_o, seg_o, frame_o} !== {exp_an, exp_seg, exp_fr}) begin
                errors++;
                $display("FAIL reset_seq n=%0d got an=%b seg=%h fr=%b want an=%b seg=%h fr=%b",
                         n, an_o, seg_o, frame_o, exp_an, exp_seg, exp_fr);
            end
        end
    endtask

    task automatic test_brightness;
        int lut [8] = '{3, 7, 11, 15, 18, 22, 26, 30};
        int c0, c3, runs;
        bit ok;
        logic prev;
        for (int b = 0; b < 8; b++) begin
            bright = 3'(b);
            sync_frame(1'b0, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bright_sync b=%0d got no frame_o want pulse", b);
            end
            c0 = 0; c3 = 0; runs = 0; prev = 1'b0;
            for (int n = 0; n < 128; n++) begin
                @(negedge clk);
                if (an_o == 4'b0001) c0++;
                if (an_o == 4'b1000) c3++;
                if ((an_o == 4'b0001) && !prev) runs++;
                prev = (an_o == 4'b0001);
            end
            checks++;
            if ((c0 != lut[b]) || (c3 != lut[b]) || (runs != 1)) begin
                errors++;
                $display("FAIL bright_lit b=%0d got d0=%0d d3=%0d runs=%0d want %0d each, 1 run",
                         b, c0, c3, runs, lut[b]);
            end
        end
    endtask

    task automatic test_snapshot;
        bit ok, changed, got;
        logic [6:0] cur, nxt;
        int c_cur, c_nxt;
        bright = 3'd7; seg_mu = 7'h66;
        sync_frame(1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL snap_sync got no frame_o want pulse");
        end
        changed = 1'b0; got = 1'b0; cur = 7'd0;
        for (int n = 0; n < 128; n++) begin
            @(negedge clk);
            if ((an_o == 4'b0010) && !changed) begin seg_mu = 7'h3F; changed = 1'b1; end
            if ((an_o == 4'b1000) && !got) begin cur = seg_o; got = 1'b1; end
        end
        got = 1'b0; nxt = 7'd0;
        for (int n = 0; n < 128; n++) begin
            @(negedge clk);
            if ((an_o == 4'b1000) && !got) begin nxt = seg_o; got = 1'b1; end
        end
        checks++;
        if ((cur !== 7'h66) || (nxt !== 7'h3F)) begin
            errors++;
            $display("FAIL snap_seg got cur=%h next=%h want 66 then 3f", cur, nxt);
        end
        changed = 1'b0; c_cur = 0; c_nxt = 0;
        for (int n = 0; n < 128; n++) begin
            @(negedge clk);
            if ((an_o == 4'b0010) && !changed) begin bright = 3'd0; changed = 1'b1; end
            if (an_o == 4'b1000) c_cur++;
        end
        for (int n = 0; n < 128; n++) begin
            @(negedge clk);
            if (an_o == 4'b1000) c_nxt++;
        end
        checks++;
        if ((c_cur != 30) || (c_nxt != 3)) begin
            errors++;
            $display("FAIL snap_bright got cur=%0d next=%0d want 30 then 3", c_cur, c_nxt);
        end
    endtask

    task automatic test_enable;
        bit ok;
        int viol;
        bright = 3'd7;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (an_o == 4'b0100) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL en_find_d2 got no digit 2 want an=0100");
        end
        en = 1'b0;
        seg_h = 7'h77;
        @(negedge clk);
        checks++;
        if ({seg_o, dp_o, an_o, frame_o} !== 13'd0) begin
            errors++;
            $display("FAIL en_off got seg=%h an=%b fr=%b want 0", seg_o, an_o, frame_o);
        end
        viol = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ({seg_o, dp_o, an_o, frame_o} !== 13'd0) viol++;
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL en_hold got %0d active cycles want 0", viol);
        end
        en = 1'b1;
        @(negedge clk);
        viol = (an_o != 4'd0) ? 1 : 0;
        @(negedge clk);
        if (an_o != 4'd0) viol++;
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL en_blank got %0d lit cycles want 0", viol);
        end
        @(negedge clk);
        checks++;
        if ((an_o !== 4'b0001) || (seg_o !== 7'h77)) begin
            errors++;
            $display("FAIL en_restart got an=%b seg=%h want an=0001 seg=77", an_o, seg_o);
        end
    endtask

    task automatic test_dp_invariants;
        bit ok;
        int dp_viol, oh_viol, gap_viol, dp_seen, zero_run;
        logic [3:0] last_an;
        dp_mask = 4'b0010;
        sync_frame(1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL inv_sync got no frame_o want pulse");
        end
        dp_viol = 0; oh_viol = 0; gap_viol = 0; dp_seen = 0;
        zero_run = 0; last_an = 4'd0;
        for (int f = 0; f < 10; f++) begin
            for (int n = 0; n < 128; n++) begin
                @(negedge clk);
                if (dp_o !== (an_o == 4'b0010)) dp_viol++;
                if (dp_o === 1'b1) dp_seen++;
                if ((an_o != 4'd0) && !$onehot(an_o)) oh_viol++;
                if (an_o != 4'd0) begin
                    if ((last_an != 4'd0) && (an_o != last_an) && (zero_run < 2)) gap_viol++;
                    last_an = an_o;
                    zero_run = 0;
                end else begin
                    zero_run++;
                end
                if (frame_o === 1'b1) begin
                    seg_h  = 7'($urandom_range(0, 127));
                    seg_hu = 7'($urandom_range(0, 127));
                    seg_mt = 7'($urandom_range(0, 127));
                    seg_mu = 7'($urandom_range(0, 127));
                    bright = 3'($urandom_range(0, 7));
                end
            end
        end
        checks++;
        if ((dp_viol != 0) || (dp_seen == 0)) begin
            errors++;
            $display("FAIL inv_dp got viol=%0d seen=%0d want 0 and >0", dp_viol, dp_seen);
        end
        checks++;
        if (oh_viol != 0) begin
            errors++;
            $display("FAIL inv_onehot got %0d want 0", oh_viol);
        end
        checks++;
        if (gap_viol != 0) begin
            errors++;
            $display("FAIL inv_gap got %0d want 0", gap_viol);
        end
    endtask

    task automatic test_variant;
        bit ok1, ok2;
        int cnt, fpos, fcnt;
        bright = 3'd7;
        sync_frame(1'b1, ok1);
        sync_frame(1'b1, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL var_sync got no v_frame want pulse");
        end
        cnt = 0; fpos = -1; fcnt = 0;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (v_an == 4'b0001) cnt++;
            if (v_frame === 1'b1) begin fpos = n; fcnt++; end
        end
        checks++;
        if (cnt != 7) begin
            errors++;
            $display("FAIL var_lit got %0d want 7", cnt);
        end
        checks++;
        if ((fpos != 32) || (fcnt != 1)) begin
            errors++;
            $display("FAIL var_period got pos=%0d count=%0d want 32 and 1", fpos, fcnt);
        end
    endtask

    initial begin
        test_reset();
        test_brightness();
        test_snapshot();
        test_enable();
        test_dp_invariants();
        test_variant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream display stage for the watch core. It consumes the four 7-bit segment buses (hours tens/units, minutes tens/units) and time-multiplexes them onto one shared segment bus plus four digit-enable lines.
- Inter-digit blanking suppresses ghosting. PWM brightness control and frame-coherent input snapshots prevent digit tearing.
- Sits between the watch core and the GPIO pads in the user-project wrapper.

Parameters:
- SCAN_DIV, 32: clock cycles per digit slot; must be > BLANK_CYC.
- BLANK_CYC, 2: cycles at start of each slot with all digits off; must be >= 1.
- PWM_BITS, 3: width of brightness_i.

Ports:
- sysclk_i  in  1  system clock (32.768 kHz).
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  scan enable; 0 blanks display and holds counters at start.
- segment_hxxx  in  7  hours-tens segments, {g..a}, active high.
- segment_xhxx  in  7  hours-units segments.
- segment_xxmx  in  7  minutes-tens segments.
- segment_xxxm  in  7  minutes-units segments.
- dp_mask_i  in  4  decimal point per digit; bit0 = hxxx.
- brightness_i  in  PWM_BITS  duty level; 0 is dimmest, all-ones is full.
- seg_o  out  7  shared segment bus, active high.
- dp_o  out  1  shared decimal point, active high.
- digit_an_o  out  4  one-hot digit enable, active high; bit0 = hxxx, bit3 = xxxm.
- frame_o  out  1  one-cycle pulse at end of each 4-digit frame.

Behaviour:
- Reset (async assert; release synchronous to sysclk_i): seg_o=0, dp_o=0, digit_an_o=0, frame_o=0, slot_cnt=0, digit_idx=0, snapshot registers=0, lit_len=0.
- Counters:
  - slot_cnt runs 0..SCAN_DIV-1.
  - On wrap, digit_idx increments 0..3, wrapping 3->0.
  - Counters advance only when en_i=1.
- Snapshot:
  - In any enabled cycle with slot_cnt=0 and digit_idx=0 (frame start), latch all four segment buses, dp_mask_i and brightness_i.
  - Input changes mid-frame have no effect until the next frame start.
- lit_len is computed at snapshot as ((SCAN_DIV-BLANK_CYC)*(brightness+1)) >> PWM_BITS, floored.
  - Defaults: brightness 7 gives 30, brightness 3 gives 15, brightness 0 gives 3.
  - Width must hold SCAN_DIV without overflow.
- Per-cycle decision for the current (digit_idx, slot_cnt):
  - Lit when BLANK_CYC <= slot_cnt < BLANK_CYC+lit_len.
  - Otherwise dark.
  - Lit: digit_an_o = 1<<digit_idx, seg_o = snapshot[digit_idx], dp_o = dp snapshot[digit_idx].
  - Dark: digit_an_o=0, seg_o=0, dp_o=0.
- Latency:
  - All outputs are registered, with exactly 1 cycle from counter state to outputs.
  - digit_an_o is never non-one-hot and never changes digit without at least BLANK_CYC all-zero cycles in between.
- On the first frame after reset or enable, the snapshot and lit_len used must be the values latched at that frame start. The frame-0 decision uses the values being latched in that cycle (bypass).
- frame_o: registered pulse, high for one cycle after the cycle with digit_idx=3 and slot_cnt=SCAN_DIV-1. Period is 4*SCAN_DIV cycles.
- en_i=0:
  - Next cycle: counters go to 0, all outputs 0, frame_o 0.
  - Snapshot registers hold.
  - On en_i rising, scanning restarts at digit 0, slot 0 with a fresh snapshot.
- Reset mid-frame: immediate (asynchronous) return to reset values. After release, the frame restarts at digit 0.

Test Plan:
1. Reset check: assert rst_i mid-clock -> all outputs 0 immediately. Release with en_i=1, brightness 7, segments hxxx=7'h06, xhxx=7'h5B, xxmx=7'h4F, xxxm=7'h66.
   - Outputs dark for cycles 1-2 after release (blanking plus latency).
   - Then digit_an_o=4'b0001 with seg_o=7'h06 for 30 cycles, 2 dark, then 4'b0010 with seg_o=7'h5B, and so on.
   - frame_o pulses every 128 cycles.
2. Brightness 0: each digit lit exactly 3 consecutive cycles per 32-cycle slot. brightness 3 -> exactly 15. Sweep levels 0..7 and check lit count = floor(30*(b+1)/8).
3. Snapshot coherence: change segment_xxxm from 7'h66 to 7'h3F while digit 1 is displayed -> current frame still shows 7'h66 on digit 3; next frame shows 7'h3F. Repeat the check for a brightness change.
4. Enable gating: drop en_i during digit 2 -> one cycle later all outputs 0 and no frame_o. Re-raise -> digit 0 lit after BLANK_CYC+1 cycles.
5. DP and one-hot invariants: dp_mask_i=4'b0010 -> dp_o high only while digit_an_o=4'b0010. Over 10 random frames, assert digit_an_o is zero or one-hot, with at least 2 zero cycles between different digits.
6. Parameter variant: SCAN_DIV=8, BLANK_CYC=1, PWM_BITS=3, brightness 7 -> 7 lit cycles per slot, frame_o period 32.
